// File: rtl/sirv_expl_apb_pkg.sv
// Shared constants for the example APB register bank.
//   - Register offsets, relative to NREG, of the control block that follows the
//     scratch registers.
//   - Bit positions inside CTRL and STATUS.
//   - Encoding of the access-phase wait-state FSM.
package sirv_expl_apb_pkg;

  localparam int CTRL_OFS = 0;
  localparam int CNT_OFS  = 1;
  localparam int CMP_OFS  = 2;
  localparam int STAT_OFS = 3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int STAT_MATCH = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1
  } wait_state_e;

endpackage

// File: rtl/sirv_expl_apb_wait.sv
// Access-phase wait-state generator for an APB slave.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   pselx, penable    : APB select and access-phase strobe from the master
//   pready            : transfer completion towards the master
//   access_done       : one-cycle pulse on the cycle a transfer completes
//   state             : current FSM state, for observation
//
// Handshake: a transfer completes on the single cycle where pselx, penable and
// pready are all 1. The slave holds pready low for WAIT_CYC access cycles and
// raises it on the next one. The master keeps pselx high until completion;
// dropping pselx abandons the transfer.
module sirv_expl_apb_wait
  import sirv_expl_apb_pkg::*;
#(
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pselx,
  input  logic        penable,
  output logic        pready,
  output logic        access_done,
  output wait_state_e state
);

  wait_state_e state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pready       = 1'b0;
    access_done  = 1'b0;
    case (state)
      // Any select seen while idle starts a transfer. A master that raises
      // penable together with pselx still pays the full wait, so it never
      // gets an early ready.
      IDLE: begin
        if (pselx) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = 4'(WAIT_CYC);
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == 4'd0) begin
          pready      = penable;
          access_done = penable;
          if (penable) state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/sirv_expl_apb_regbank.sv
// Example APB slave: NREG scratch registers followed by a control block
// (CTRL, free-running CNT, CMP, STATUS) that raises a level interrupt when
// the counter reaches the compare value.
// Ports:
//   clk, rst_n                 : clock and synchronous active-low reset
//   apb_paddr                  : byte address, only [11:2] decoded
//   apb_pwrite                 : 1 = write, 0 = read
//   apb_pselx, apb_penable     : select and access-phase strobe
//   apb_pwdata                 : write data
//   apb_prdata                 : read data, 0 unless a good transfer is ready
//   apb_pready                 : transfer completion (WAIT_CYC wait states)
//   apb_pslverr                : error response, only together with apb_pready
//   irq                        : STATUS.match & CTRL.ie
//   wait_state                 : wait-state FSM state, for observation
module sirv_expl_apb_regbank
  import sirv_expl_apb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int NREG     = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] apb_paddr,
  input  logic          apb_pwrite,
  input  logic          apb_pselx,
  input  logic          apb_penable,
  input  logic [DW-1:0] apb_pwdata,
  output logic [DW-1:0] apb_prdata,
  output logic          apb_pready,
  output logic          apb_pslverr,
  output logic          irq,
  output wait_state_e   wait_state
);

  localparam int SW = $clog2(NREG);
  localparam logic [9:0] IDX_NREG = 10'(NREG);
  localparam logic [9:0] IDX_CTRL = 10'(NREG + CTRL_OFS);
  localparam logic [9:0] IDX_CNT  = 10'(NREG + CNT_OFS);
  localparam logic [9:0] IDX_CMP  = 10'(NREG + CMP_OFS);
  localparam logic [9:0] IDX_STAT = 10'(NREG + STAT_OFS);

  logic [DW-1:0] scr [NREG];
  logic          en;
  logic          ie;
  logic          match;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cmp;

  logic          pready;
  logic          access_done;
  logic [9:0]    idx;
  logic          addr_err;
  logic          wr;
  logic          match_set;
  logic [DW-1:0] rdata;
  logic          unused_paddr;

  // Upper address bits are outside the decoded window by design.
  assign unused_paddr = ^apb_paddr;

  sirv_expl_apb_wait #(
    .WAIT_CYC(WAIT_CYC)
  ) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .pselx      (apb_pselx),
    .penable    (apb_penable),
    .pready     (pready),
    .access_done(access_done),
    .state      (wait_state)
  );

  assign idx      = apb_paddr[11:2];
  assign addr_err = (idx > IDX_STAT) || (apb_paddr[1:0] != 2'b00);
  assign wr       = access_done & apb_pwrite & ~addr_err;

  // Compare uses the pre-write counter, so a same-cycle CNT write cannot
  // suppress a match already reached.
  assign match_set = en & (cnt == cmp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) scr[i] <= '0;
      en    <= 1'b0;
      ie    <= 1'b0;
      match <= 1'b0;
      cnt   <= '0;
      cmp   <= '0;
    end else begin
      if (wr && idx < IDX_NREG) scr[idx[SW-1:0]] <= apb_pwdata;
      if (wr && idx == IDX_CTRL) begin
        en <= apb_pwdata[CTRL_EN];
        ie <= apb_pwdata[CTRL_IE];
      end
      // A bus write to CNT overrides the increment.
      if (wr && idx == IDX_CNT) cnt <= apb_pwdata;
      else if (en)              cnt <= cnt + DW'(1);
      if (wr && idx == IDX_CMP) cmp <= apb_pwdata;
      // Set beats write-1-to-clear.
      if (match_set)
        match <= 1'b1;
      else if (wr && idx == IDX_STAT && apb_pwdata[STAT_MATCH])
        match <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (idx < IDX_NREG) begin
      rdata = scr[idx[SW-1:0]];
    end else begin
      case (idx)
        IDX_CTRL: begin
          rdata[CTRL_EN] = en;
          rdata[CTRL_IE] = ie;
        end
        IDX_CNT:  rdata = cnt;
        IDX_CMP:  rdata = cmp;
        IDX_STAT: rdata[STAT_MATCH] = match;
        default:  rdata = '0;
      endcase
    end
  end

  assign apb_pready  = pready;
  assign apb_pslverr = pready & addr_err;
  assign apb_prdata  = (pready && !addr_err) ? rdata : '0;
  assign irq         = match & ie;

endmodule
